// File: rtl/z80_bus_ctrl_pkg.sv
// Shared constants, types and helpers for the Z80 bus controller.
// Imported by the interface, the clock generator and the top level.
package z80_bus_ctrl_pkg;

  localparam int unsigned DefNumIo       = 3;
  localparam logic [7:0]  DefIoBase      = 8'h80;
  localparam int unsigned DefIoSpanLog2  = 3;
  localparam logic [7:0]  DefMapBase     = 8'hF0;
  localparam int unsigned DefPageBits    = 4;
  localparam int unsigned DefRomAWidth   = 13;
  localparam int unsigned DefClkDiv      = 5;
  localparam int unsigned DefClkLo       = 2;
  localparam int unsigned DefWaitCycles  = 1;

  // Offsets from MAP_BASE: 0..3 are page registers, 4 is ROM control.
  localparam int unsigned MapNumPages    = 4;
  localparam logic [7:0]  MapOffRomCtl   = 8'd4;
  localparam logic [7:0]  MapNumPorts    = 8'd5;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHold
  } wait_st_e;

  function automatic int unsigned pa_width(input int unsigned page_bits);
    return 14 + page_bits;
  endfunction

  function automatic logic [7:0] io_chan_base(input logic [7:0]  base,
                                              input int unsigned span_log2,
                                              input int unsigned idx);
    return base + 8'(idx << span_log2);
  endfunction

endpackage

// File: rtl/z80_bus_ctrl_if.sv
// Z80 CPU bus as seen by the bus controller: address/data/strobes in,
// read data, wait and the generated CPU clock out.
interface z80_bus_ctrl_if;
  import z80_bus_ctrl_pkg::*;

  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  cpu_din;
  logic        wait_n;
  logic        cpu_clk;

  modport master (
    output cpu_a, cpu_dout, mreq_n, iorq_n, rd_n, wr_n,
    input  cpu_din, wait_n, cpu_clk
  );

  modport slave (
    input  cpu_a, cpu_dout, mreq_n, iorq_n, rd_n, wr_n,
    output cpu_din, wait_n, cpu_clk
  );
endinterface

// File: rtl/z80_clk_gen.sv
// Divides the system clock into a registered CPU clock and flags the
// system-clock edge on which the CPU clock will rise.
module z80_clk_gen
  import z80_bus_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = DefClkDiv,
  parameter int unsigned CLK_LO  = DefClkLo
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_cpu_clk,
  output logic o_rise
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LastCnt = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LoCnt   = CW'(CLK_LO);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_cpu_clk;
  logic          w_high_nxt;

  always_comb begin
    w_cnt_nxt  = (r_cnt == LastCnt) ? '0 : r_cnt + 1'b1;
    w_high_nxt = (w_cnt_nxt >= LoCnt);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_cpu_clk <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_cpu_clk <= w_high_nxt;
    end
  end

  assign o_cpu_clk = r_cpu_clk;
  // True during the cycle whose closing edge takes cpu_clk from 0 to 1.
  assign o_rise    = ~r_cpu_clk & w_high_nxt;

endmodule

// File: rtl/z80_bus_ctrl.sv
// Z80 glue: I/O and memory chip selects, 16K paging, ROM overlay,
// read-data mux and memory wait-state insertion.
module z80_bus_ctrl
  import z80_bus_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IO       = DefNumIo,
  parameter logic [7:0]  IO_BASE      = DefIoBase,
  parameter int unsigned IO_SPAN_LOG2 = DefIoSpanLog2,
  parameter logic [7:0]  MAP_BASE     = DefMapBase,
  parameter int unsigned PAGE_BITS    = DefPageBits,
  parameter int unsigned ROM_A_WIDTH  = DefRomAWidth,
  parameter int unsigned CLK_DIV      = DefClkDiv,
  parameter int unsigned CLK_LO       = DefClkLo,
  parameter int unsigned WAIT_CYCLES  = DefWaitCycles,
  localparam int unsigned PA_W        = pa_width(PAGE_BITS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  z80_bus_ctrl_if.slave         bus,
  output logic [PA_W-1:0]       o_phys_a,
  output logic                  o_rom_cs_n,
  output logic                  o_ram_cs_n,
  output logic [NUM_IO-1:0]     o_io_cs_n,
  input  logic [7:0]            i_rom_dout,
  input  logic [7:0]            i_ram_dout,
  input  logic [NUM_IO*8-1:0]   i_io_dout
);

  localparam int unsigned WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WW-1:0] WaitLast = WW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic                 w_rise;
  logic [PAGE_BITS-1:0] r_page [MapNumPages];
  logic                 r_rom_en;
  logic                 r_iow_q;
  logic                 r_mem_q;
  wait_st_e             r_state, w_state_nxt;
  logic [WW-1:0]        r_wcnt, w_wcnt_nxt;

  logic                 w_io_cyc, w_iow, w_iow_start;
  logic [7:0]           w_map_off;
  logic                 w_map_port, w_map_rd;
  logic [7:0]           w_map_data;
  logic                 w_mem, w_mem_fall, w_rom_sel;
  logic [NUM_IO-1:0]    w_io_sel;
  logic [7:0]           w_din;
  logic                 w_unused_dout;

  z80_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .CLK_LO  (CLK_LO)
  ) u_clk_gen (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .o_cpu_clk (bus.cpu_clk),
    .o_rise    (w_rise)
  );

  // Address decode
  always_comb begin
    w_io_cyc    = ~bus.iorq_n & (~bus.rd_n | ~bus.wr_n);
    w_iow       = ~bus.iorq_n & ~bus.wr_n;
    w_iow_start = w_iow & ~r_iow_q;
    w_map_off   = bus.cpu_a[7:0] - MAP_BASE;
    w_map_port  = (w_map_off < MapNumPorts);
    w_map_rd    = ~bus.iorq_n & ~bus.rd_n & w_map_port;
    w_mem       = ~bus.mreq_n;
    w_mem_fall  = w_mem & ~r_mem_q;
    w_rom_sel   = r_rom_en && (bus.cpu_a[15:ROM_A_WIDTH] == '0);

    w_io_sel = '0;
    for (int unsigned i = 0; i < NUM_IO; i++) begin
      // A map port shadows any I/O channel that overlaps it.
      if (w_io_cyc && !w_map_port &&
          ((bus.cpu_a[7:0] >> IO_SPAN_LOG2) ==
           (io_chan_base(IO_BASE, IO_SPAN_LOG2, i) >> IO_SPAN_LOG2))) begin
        w_io_sel[i] = 1'b1;
      end
    end

    if (w_map_off == MapOffRomCtl) begin
      w_map_data = {7'b0, ~r_rom_en};
    end else begin
      w_map_data = 8'(r_page[w_map_off[1:0]]);
    end
  end

  // Read mux, assigned from lowest to highest priority
  always_comb begin
    w_din = 8'hFF;
    if (w_mem && !w_rom_sel) w_din = i_ram_dout;
    if (w_mem && w_rom_sel)  w_din = i_rom_dout;
    if (w_map_rd)            w_din = w_map_data;
    for (int i = int'(NUM_IO) - 1; i >= 0; i--) begin
      if (w_io_sel[i]) w_din = i_io_dout[8*i +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned n = 0; n < MapNumPages; n++) begin
        r_page[n] <= PAGE_BITS'(n);
      end
      r_rom_en <= 1'b1;
      r_iow_q  <= 1'b0;
    end else begin
      r_iow_q <= w_iow;
      if (w_iow_start && w_map_port) begin
        if (w_map_off == MapOffRomCtl) begin
          r_rom_en <= ~bus.cpu_dout[0];
        end else begin
          r_page[w_map_off[1:0]] <= bus.cpu_dout[PAGE_BITS-1:0];
        end
      end
    end
  end

  // Wait-state FSM
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_wcnt  <= '0;
      r_mem_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_mem_q <= w_mem;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    unique case (r_state)
      StIdle: begin
        if (w_mem_fall && (WAIT_CYCLES != 0)) begin
          w_state_nxt = StWait;
          w_wcnt_nxt  = '0;
        end
      end
      StWait: begin
        if (!w_mem) begin
          w_state_nxt = StIdle;
        end else if (w_rise) begin
          if (r_wcnt == WaitLast) w_state_nxt = StHold;
          else                    w_wcnt_nxt  = r_wcnt + 1'b1;
        end
      end
      StHold: begin
        if (!w_mem) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign bus.wait_n    = (r_state != StWait);
  assign bus.cpu_din   = w_din;
  assign o_phys_a      = {r_page[bus.cpu_a[15:14]], bus.cpu_a[13:0]};
  assign o_rom_cs_n    = ~(w_mem & w_rom_sel);
  assign o_ram_cs_n    = ~(w_mem & ~w_rom_sel);
  assign o_io_cs_n     = ~w_io_sel;
  assign w_unused_dout = ^bus.cpu_dout;

endmodule
